// File: rtl/baw_pkg.sv
// Shared constants for the Black-and-White card ledger.
// Holds the hand size, the full-hand reset mask, the match_result encodings and
// the card colour rule (odd-numbered cards are black, even-numbered are white).
package baw_pkg;

  localparam int unsigned NUM_CARDS = 9;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned HAND_W    = 4;

  localparam logic [NUM_CARDS-1:0] FULL_HAND = 9'h1FF;

  localparam logic [1:0] MATCH_DRAW = 2'b00;
  localparam logic [1:0] MATCH_P1   = 2'b01;
  localparam logic [1:0] MATCH_P2   = 2'b10;

  // Colour rule: card k is black when k is odd.
  function automatic logic is_black(input int unsigned idx);
    return idx[0];
  endfunction

endpackage

// File: rtl/baw_colour_count.sv
// Colour tally for one player's hand.
// Ports:
//   mask_i  - remaining-card mask, bit k = card k still held
//   black_o - number of held odd (black) cards, zero-extended
//   white_o - number of held even (white) cards, zero-extended
module baw_colour_count
  import baw_pkg::*;
(
  input  logic [NUM_CARDS-1:0] mask_i,
  output logic [CNT_W-1:0]     black_o,
  output logic [CNT_W-1:0]     white_o
);

  logic [CNT_W-1:0] black_cnt;
  logic [CNT_W-1:0] white_cnt;

  always_comb begin
    black_cnt = '0;
    white_cnt = '0;
    for (int unsigned i = 0; i < NUM_CARDS; i++) begin
      if (is_black(i)) begin
        black_cnt = black_cnt + CNT_W'(mask_i[i]);
      end else begin
        white_cnt = white_cnt + CNT_W'(mask_i[i]);
      end
    end
  end

  assign black_o = black_cnt;
  assign white_o = white_cnt;

endmodule

// File: rtl/baw_card_ledger.sv
// Card ledger for both players of the Black-and-White game.
// Keeps each player's remaining-card mask, retires the cards selected by sel
// when that player's play strobe is high, and derives colour tallies plus the
// round winner from the two played hand values.
// Ports:
//   clk                - clock, state updates on rising edge
//   resetn             - synchronous reset, active-high; refills both hands
//   sel                - card-select mask, bit k = card k
//   p1_play / p2_play  - retire sel cards from that player this cycle
//   p1_hand / p2_hand  - card values played this round
//   p1_card / p2_card  - remaining-card masks (1 = still held)
//   p1_black/p1_white  - held black / white card counts, player 1
//   p2_black/p2_white  - held black / white card counts, player 2
//   match_result       - 01 p1 wins, 10 p2 wins, 00 draw
module baw_card_ledger
  import baw_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_CARDS-1:0] sel,
  input  logic                 p1_play,
  input  logic                 p2_play,
  input  logic [HAND_W-1:0]    p1_hand,
  input  logic [HAND_W-1:0]    p2_hand,
  output logic [NUM_CARDS-1:0] p1_card,
  output logic [NUM_CARDS-1:0] p2_card,
  output logic [CNT_W-1:0]     p1_black,
  output logic [CNT_W-1:0]     p1_white,
  output logic [CNT_W-1:0]     p2_black,
  output logic [CNT_W-1:0]     p2_white,
  output logic [1:0]           match_result
);

  logic [NUM_CARDS-1:0] p1_card_q, p1_card_d;
  logic [NUM_CARDS-1:0] p2_card_q, p2_card_d;

  // Clearing with AND-NOT makes repeated or already-retired selections harmless.
  always_comb begin
    p1_card_d = p1_card_q;
    p2_card_d = p2_card_q;
    if (p1_play) p1_card_d = p1_card_q & ~sel;
    if (p2_play) p2_card_d = p2_card_q & ~sel;
  end

  // resetn is active-high despite its name and overrides any play strobe.
  always_ff @(posedge clk) begin
    if (resetn) begin
      p1_card_q <= FULL_HAND;
      p2_card_q <= FULL_HAND;
    end else begin
      p1_card_q <= p1_card_d;
      p2_card_q <= p2_card_d;
    end
  end

  assign p1_card = p1_card_q;
  assign p2_card = p2_card_q;

  baw_colour_count u_p1_count (
    .mask_i  (p1_card_q),
    .black_o (p1_black),
    .white_o (p1_white)
  );

  baw_colour_count u_p2_count (
    .mask_i  (p2_card_q),
    .black_o (p2_black),
    .white_o (p2_white)
  );

  // Plain unsigned compare; out-of-range hand values are not saturated.
  always_comb begin
    match_result = MATCH_DRAW;
    if (p1_hand > p2_hand) begin
      match_result = MATCH_P1;
    end else if (p2_hand > p1_hand) begin
      match_result = MATCH_P2;
    end
  end

endmodule

// File: tb/tb_baw_card_ledger.sv
module tb_baw_card_ledger;

  typedef struct {
    logic       rst;
    logic       p1p;
    logic       p2p;
    logic [8:0] sel;
    logic [3:0] h1;
    logic [3:0] h2;
    logic [8:0] e_p1;
    logic [8:0] e_p2;
    logic [3:0] e_p1b;
    logic [3:0] e_p1w;
    logic [3:0] e_p2b;
    logic [3:0] e_p2w;
    logic [1:0] e_m;
  } vec_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [8:0] sel = '0;
  logic       p1_play = 1'b0;
  logic       p2_play = 1'b0;
  logic [3:0] p1_hand = '0;
  logic [3:0] p2_hand = '0;
  logic [8:0] p1_card;
  logic [8:0] p2_card;
  logic [3:0] p1_black;
  logic [3:0] p1_white;
  logic [3:0] p2_black;
  logic [3:0] p2_white;
  logic [1:0] match_result;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  baw_card_ledger dut (
    .clk          (clk),
    .resetn       (resetn),
    .sel          (sel),
    .p1_play      (p1_play),
    .p2_play      (p2_play),
    .p1_hand      (p1_hand),
    .p2_hand      (p2_hand),
    .p1_card      (p1_card),
    .p2_card      (p2_card),
    .p1_black     (p1_black),
    .p1_white     (p1_white),
    .p2_black     (p2_black),
    .p2_white     (p2_white),
    .match_result (match_result)
  );

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic p1p, input logic p2p, input logic [8:0] s,
                     input logic [3:0] h1, input logic [3:0] h2,
                     input logic [8:0] e1, input logic [8:0] e2,
                     input logic [3:0] b1, input logic [3:0] w1,
                     input logic [3:0] b2, input logic [3:0] w2, input logic [1:0] m);
    vec_t v;
    v.rst = rst; v.p1p = p1p; v.p2p = p2p; v.sel = s; v.h1 = h1; v.h2 = h2;
    v.e_p1 = e1; v.e_p2 = e2; v.e_p1b = b1; v.e_p1w = w1; v.e_p2b = b2; v.e_p2w = w2;
    v.e_m = m;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic p1p, input logic p2p, input logic [8:0] s,
                       input logic [3:0] h1, input logic [3:0] h2);
    @(negedge clk);
    resetn = rst; p1_play = p1p; p2_play = p2p; sel = s; p1_hand = h1; p2_hand = h2;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, " p1_card"}, p1_card, v.e_p1);
    chk({tag, " p2_card"}, p2_card, v.e_p2);
    chk({tag, " p1_black"}, {5'b0, p1_black}, {5'b0, v.e_p1b});
    chk({tag, " p1_white"}, {5'b0, p1_white}, {5'b0, v.e_p1w});
    chk({tag, " p2_black"}, {5'b0, p2_black}, {5'b0, v.e_p2b});
    chk({tag, " p2_white"}, {5'b0, p2_white}, {5'b0, v.e_p2w});
    chk({tag, " match"}, {7'b0, match_result}, {7'b0, v.e_m});
  endtask

  initial begin
    //   rst p1 p2 sel     h1 h2  p1     p2     b1 w1 b2 w2 match
    add(1, 0, 0, 9'h000, 0, 0, 9'h1FF, 9'h1FF, 4, 5, 4, 5, 2'b00);  // reset
    add(0, 1, 0, 9'h008, 7, 2, 9'h1F7, 9'h1FF, 3, 5, 4, 5, 2'b01);  // retire card 3
    add(0, 1, 0, 9'h008, 2, 7, 9'h1F7, 9'h1FF, 3, 5, 4, 5, 2'b10);  // held strobe
    add(0, 1, 0, 9'h008, 5, 5, 9'h1F7, 9'h1FF, 3, 5, 4, 5, 2'b00);
    add(0, 1, 0, 9'h008, 0, 8, 9'h1F7, 9'h1FF, 3, 5, 4, 5, 2'b10);
    add(0, 1, 0, 9'h008, 8, 0, 9'h1F7, 9'h1FF, 3, 5, 4, 5, 2'b01);
    add(0, 1, 0, 9'h008, 15, 9, 9'h1F7, 9'h1FF, 3, 5, 4, 5, 2'b01); // repeat + >8 compare
    add(0, 1, 1, 9'h000, 9, 12, 9'h1F7, 9'h1FF, 3, 5, 4, 5, 2'b10); // sel=0 no change
    add(0, 0, 0, 9'h1FF, 3, 3, 9'h1F7, 9'h1FF, 3, 5, 4, 5, 2'b00);  // no strobe
    add(1, 0, 0, 9'h000, 0, 0, 9'h1FF, 9'h1FF, 4, 5, 4, 5, 2'b00);
    add(0, 1, 1, 9'h101, 1, 0, 9'h0FE, 9'h0FE, 4, 3, 4, 3, 2'b01);  // simultaneous
    add(1, 1, 0, 9'h1FF, 0, 1, 9'h1FF, 9'h1FF, 4, 5, 4, 5, 2'b10);  // reset wins
    // p2 exhaustion, one card per cycle
    add(0, 0, 1, 9'h001, 0, 0, 9'h1FF, 9'h1FE, 4, 5, 4, 4, 2'b00);
    add(0, 0, 1, 9'h002, 0, 0, 9'h1FF, 9'h1FC, 4, 5, 3, 4, 2'b00);
    add(0, 0, 1, 9'h004, 0, 0, 9'h1FF, 9'h1F8, 4, 5, 3, 3, 2'b00);
    add(0, 0, 1, 9'h008, 0, 0, 9'h1FF, 9'h1F0, 4, 5, 2, 3, 2'b00);
    add(0, 0, 1, 9'h010, 0, 0, 9'h1FF, 9'h1E0, 4, 5, 2, 2, 2'b00);
    add(0, 0, 1, 9'h020, 0, 0, 9'h1FF, 9'h1C0, 4, 5, 1, 2, 2'b00);
    add(0, 0, 1, 9'h040, 0, 0, 9'h1FF, 9'h180, 4, 5, 1, 1, 2'b00);
    add(0, 0, 1, 9'h080, 0, 0, 9'h1FF, 9'h100, 4, 5, 0, 1, 2'b00);
    add(0, 0, 1, 9'h100, 0, 0, 9'h1FF, 9'h000, 4, 5, 0, 0, 2'b00);
    add(0, 0, 1, 9'h1FF, 0, 0, 9'h1FF, 9'h000, 4, 5, 0, 0, 2'b00);  // already empty
    add(0, 0, 1, 9'h001, 0, 0, 9'h1FF, 9'h000, 4, 5, 0, 0, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].p1p, vecs[i].p2p, vecs[i].sel, vecs[i].h1, vecs[i].h2);
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Multi-cycle: restore hands, then hold p1 retiring all black cards for 5 cycles.
    begin
      vec_t v;
      drive(1, 0, 1, 9'h1FF, 0, 0);
      v.e_p1 = 9'h155; v.e_p2 = 9'h1FF; v.e_p1b = 0; v.e_p1w = 5; v.e_p2b = 4; v.e_p2w = 5;
      v.e_m = 2'b00;
      for (int c = 0; c < 5; c++) begin
        drive(0, 1, 0, 9'h0AA, 4'(c), 4'(c));
        check_all($sformatf("hold%0d", c), v);
      end
      // Reset mid-game with both strobes retiring everything.
      drive(1, 1, 1, 9'h1FF, 6, 4);
      v.e_p1 = 9'h1FF; v.e_p1b = 4; v.e_p1w = 5; v.e_m = 2'b01;
      check_all("midreset", v);
      // Comparator responds without a clock edge.
      @(negedge clk);
      resetn = 0; p1_play = 0; p2_play = 0;
      p1_hand = 4'd3; p2_hand = 4'd4;
      #1;
      chk("comb match", {7'b0, match_result}, 9'h002);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
